// File: rtl/key_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | key_pkg : shared state encoding and defaults for key debouncing  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package key_pkg;

   typedef enum logic [1:0] {
      ST_UP    = 2'b00,
      ST_GO_DN = 2'b01,
      ST_DN    = 2'b11,
      ST_GO_UP = 2'b10
   } key_state_e;

   localparam int C_DEBOUNCE_CYCLES = 500000;
   localparam int C_CNT_W           = 20;

endpackage
`default_nettype wire

// File: rtl/key_debounce_cell.sv
`default_nettype none
// +------------------------------------------------------------------+
// | key_debounce_cell : 2-flop sync, debounce FSM and strobes, 1 key |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module key_debounce_cell
   import key_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = C_DEBOUNCE_CYCLES,
   parameter int CNT_W           = C_CNT_W
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_raw,
   output logic key_clean,
   output logic key_press,
   output logic key_release
);

   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync_q, sync_d;
   key_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             clean_q, clean_d;
   logic             press_q, press_d;
   logic             rel_q, rel_d;
   logic             s2;

   // sync_q[0] is the metastability flop, sync_q[1] the stable sample
   assign s2 = sync_q[1];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q  <= 2'b11;
         state_q <= ST_UP;
         cnt_q   <= '0;
         clean_q <= 1'b1;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         clean_q <= clean_d;
         press_q <= press_d;
         rel_q   <= rel_d;
      end
   end

   always_comb begin
      sync_d  = {sync_q[0], key_raw};
      state_d = state_q;
      cnt_d   = cnt_q;
      clean_d = clean_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      unique case (state_q)
         ST_UP: begin
            if (!s2) begin
               state_d = ST_GO_DN;
               cnt_d   = '0;
            end
         end
         ST_GO_DN: begin
            if (s2) begin
               state_d = ST_UP;
               cnt_d   = '0;
            end else if (cnt_q == C_CNT_LAST) begin
               state_d = ST_DN;
               cnt_d   = '0;
               clean_d = 1'b0;
               press_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DN: begin
            if (s2) begin
               state_d = ST_GO_UP;
               cnt_d   = '0;
            end
         end
         ST_GO_UP: begin
            if (!s2) begin
               state_d = ST_DN;
               cnt_d   = '0;
            end else if (cnt_q == C_CNT_LAST) begin
               state_d = ST_UP;
               cnt_d   = '0;
               clean_d = 1'b1;
               rel_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_UP;
            cnt_d   = '0;
         end
      endcase
   end

   assign key_clean   = clean_q;
   assign key_press   = press_q;
   assign key_release = rel_q;

endmodule
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// +------------------------------------------------------------------+
// | key_debounce : independent debouncers for active-low buttons     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module key_debounce
   import key_pkg::*;
#(
   parameter int NUM_KEYS        = 4,
   parameter int DEBOUNCE_CYCLES = C_DEBOUNCE_CYCLES,
   parameter int CNT_W           = C_CNT_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_KEYS-1:0] key_raw,
   output logic [NUM_KEYS-1:0] key_clean,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release
);

   for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
      key_debounce_cell #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_cell (
         .clk         (clk),
         .rst_n       (rst_n),
         .key_raw     (key_raw[g]),
         .key_clean   (key_clean[g]),
         .key_press   (key_press[g]),
         .key_release (key_release[g])
      );
   end

endmodule
`default_nettype wire

// File: tb/tb_key_debounce.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_key_debounce : directed and random checks vs a window model   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_key_debounce;

   localparam int NK = 4;
   localparam int DB = 4;
   localparam int WN = DB + 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NK-1:0] key_raw;
   logic [NK-1:0] key_clean, key_press, key_release;

   int checks = 0;
   int errors = 0;

   // Model: raw is seen by the debouncer two edges late; the clean level
   // flips once the last DB+1 delayed samples all disagree with it.
   logic [NK-1:0] m_p1, m_p2;
   logic [NK-1:0] m_win [WN];
   logic [NK-1:0] exp_clean, exp_press, exp_rel;

   key_debounce #(
      .NUM_KEYS        (NK),
      .DEBOUNCE_CYCLES (DB),
      .CNT_W           (3)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_raw     (key_raw),
      .key_clean   (key_clean),
      .key_press   (key_press),
      .key_release (key_release)
   );

   always #5 clk = ~clk;

   task automatic model_step(input logic rst_v, input logic [NK-1:0] raw_v);
      logic [NK-1:0] seen;
      logic          all_lo, all_hi;
      exp_press = '0;
      exp_rel   = '0;
      if (!rst_v) begin
         m_p1 = '1;
         m_p2 = '1;
         for (int j = 0; j < WN; j++) m_win[j] = '1;
         exp_clean = '1;
      end else begin
         seen = m_p2;
         m_p2 = m_p1;
         m_p1 = raw_v;
         for (int j = WN - 1; j > 0; j--) m_win[j] = m_win[j-1];
         m_win[0] = seen;
         for (int k = 0; k < NK; k++) begin
            all_lo = 1'b1;
            all_hi = 1'b1;
            for (int j = 0; j < WN; j++) begin
               if (m_win[j][k]) all_lo = 1'b0;
               else             all_hi = 1'b0;
            end
            if (all_lo && exp_clean[k]) begin
               exp_clean[k] = 1'b0;
               exp_press[k] = 1'b1;
            end else if (all_hi && !exp_clean[k]) begin
               exp_clean[k] = 1'b1;
               exp_rel[k]   = 1'b1;
            end
         end
      end
   endtask

   // Inputs change on the falling edge; outputs are observed 1 ns after the rising edge.
   task automatic drive(input logic rst_v, input logic [NK-1:0] raw_v);
      @(negedge clk);
      rst_n   = rst_v;
      key_raw = raw_v;
      model_step(rst_v, raw_v);
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      for (int i = 0; i < 12; i++) drive(1'b1, '1);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 4'b0000);
         checks++;
         if ({key_clean, key_press, key_release} !== {4'b1111, 4'b0000, 4'b0000}) begin
            errors++;
            $display("FAIL reset cyc%0d: got clean=%b press=%b rel=%b want 1111/0000/0000",
                     i, key_clean, key_press, key_release);
         end
      end
      settle();
   endtask

   task automatic test_press();
      for (int e = 0; e <= 8; e++) begin
         drive(1'b1, 4'b1110);
         checks++;
         if (key_clean[0] !== (e < 6 ? 1'b1 : 1'b0) || key_press[0] !== (e == 6 ? 1'b1 : 1'b0)
             || key_release !== 4'b0000) begin
            errors++;
            $display("FAIL press edge%0d: got clean=%b press=%b rel=%b", e, key_clean, key_press, key_release);
         end
      end
      settle();
   endtask

   task automatic test_bounce();
      for (int e = 0; e < 3; e++) drive(1'b1, 4'b1101);
      for (int e = 0; e < 10; e++) begin
         drive(1'b1, 4'b1111);
         checks++;
         if (key_clean !== 4'b1111 || key_press !== 4'b0000 || key_release !== 4'b0000) begin
            errors++;
            $display("FAIL bounce cyc%0d: got clean=%b press=%b rel=%b want 1111/0000/0000",
                     e, key_clean, key_press, key_release);
         end
      end
      // a clean press afterwards must take the full latency again
      for (int e = 0; e <= 7; e++) begin
         drive(1'b1, 4'b1101);
         checks++;
         if (key_press[1] !== (e == 6 ? 1'b1 : 1'b0)) begin
            errors++;
            $display("FAIL bounce_repress edge%0d: got press=%b", e, key_press);
         end
      end
      settle();
   endtask

   task automatic test_release();
      for (int e = 0; e < 10; e++) drive(1'b1, 4'b1011);
      checks++;
      if (key_clean !== 4'b1011) begin
         errors++;
         $display("FAIL release_pre: got clean=%b want 1011", key_clean);
      end
      for (int e = 0; e <= 8; e++) begin
         drive(1'b1, 4'b1111);
         checks++;
         if (key_release[2] !== (e == 6 ? 1'b1 : 1'b0) || key_clean[2] !== (e < 6 ? 1'b0 : 1'b1)
             || key_press !== 4'b0000) begin
            errors++;
            $display("FAIL release edge%0d: got clean=%b press=%b rel=%b", e, key_clean, key_press, key_release);
         end
      end
      settle();
   endtask

   task automatic test_simultaneous();
      for (int e = 0; e <= 7; e++) begin
         drive(1'b1, 4'b0000);
         checks++;
         if (key_press !== (e == 6 ? 4'b1111 : 4'b0000) || key_clean !== (e < 6 ? 4'b1111 : 4'b0000)) begin
            errors++;
            $display("FAIL simultaneous edge%0d: got clean=%b press=%b", e, key_clean, key_press);
         end
      end
      settle();
   endtask

   task automatic test_reset_midcount();
      for (int e = 0; e <= 4; e++) drive(1'b1, 4'b0111);
      drive(1'b0, 4'b0111);
      checks++;
      if (key_press !== 4'b0000 || key_release !== 4'b0000 || key_clean !== 4'b1111) begin
         errors++;
         $display("FAIL midreset: got clean=%b press=%b rel=%b want 1111/0000/0000", key_clean, key_press, key_release);
      end
      for (int e = 0; e <= 7; e++) begin
         drive(1'b1, 4'b0111);
         checks++;
         if (key_press !== (e == 6 ? 4'b1000 : 4'b0000)) begin
            errors++;
            $display("FAIL midreset_repress edge%0d: got press=%b", e, key_press);
         end
      end
      settle();
   endtask

   task automatic test_random();
      logic [NK-1:0] lvl;
      int            hold [NK];
      lvl = '1;
      for (int k = 0; k < NK; k++) hold[k] = 0;
      for (int c = 0; c < 600; c++) begin
         for (int k = 0; k < NK; k++) begin
            if (hold[k] == 0) begin
               lvl[k]  = ~lvl[k];
               hold[k] = (($urandom % 3) == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(5, 12));
            end
            hold[k]--;
         end
         drive(($urandom % 150) != 0, lvl);
         checks++;
         if ({key_clean, key_press, key_release} !== {exp_clean, exp_press, exp_rel}) begin
            errors++;
            $display("FAIL random cyc%0d: got clean=%b press=%b rel=%b want %b/%b/%b",
                     c, key_clean, key_press, key_release, exp_clean, exp_press, exp_rel);
         end
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      key_raw   = '1;
      m_p1      = '1;
      m_p2      = '1;
      for (int j = 0; j < WN; j++) m_win[j] = '1;
      exp_clean = '1;
      exp_press = '0;
      exp_rel   = '0;
      test_reset();
      test_press();
      test_bounce();
      test_release();
      test_simultaneous();
      test_reset_midcount();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
